// File: rtl/shift_arbiter_pkg.sv
// Shared constants and payload type for the shift arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_arbiter_pkg;

  localparam int SH_DATA_W = 32;
  localparam int SH_AMT_W  = 5;

  localparam logic SH_DIR_SRA = 1'b0;
  localparam logic SH_DIR_SLL = 1'b1;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  // Operand bundle presented to the shared shifter.
  typedef struct packed {
    logic [SH_DATA_W-1:0] data;
    logic                 dir;
    logic [SH_AMT_W-1:0]  shamt;
  } sh_req_t;

endpackage

// File: rtl/shift_arbiter_rr_arb2.sv
// Two-way round-robin grant, gated by an enable (output slot free).
// Latency: grant is combinational; last_grant state updates at the clock edge.
// Backpressure: en = 0 suppresses all grants and freezes last_grant.
//
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   en             : grants allowed this cycle
//   valid[1:0]     : request lines
//   grant[1:0]     : one-hot grant (or zero)
module rr_arb2
  import shift_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // Tie: whoever did not win last time goes first.
        2'b11:   grant = (last_grant == REQ_AUX) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Reset to the aux id so the ALU requester wins the first tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= REQ_AUX;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Arbitrates two requesters onto one external combinational barrel shifter.
// Latency: 1 cycle from accept to rsp_valid; one result per cycle sustained.
// Backpressure: a full slot with rsp_ready = 0 holds both reqN_ready low.
//
// Optional feature macro: SHIFT_ARB_PERF_EN (adds grant/conflict counters).
// Ports:
//   clock, reset_n           : clock, asynchronous active-low reset
//   reqN_valid/ready         : request handshake, N = 0 (ALU), 1 (aux)
//   reqN_data/dir/shamt/tag  : operand, 0 = SRA / 1 = SLL, amount, opaque tag
//   sh_data/dir/shamt        : drive to the shared shifter (0 when idle)
//   sh_result                : shifter output, combinational in sh_*
//   rsp_valid/ready          : response slot handshake
//   rsp_data/src/tag         : registered result, requester id, tag
//   grant0/1_cnt, conflict_cnt (SHIFT_ARB_PERF_EN only)
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,

  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [SH_DATA_W-1:0] req0_data,
  input  logic                 req0_dir,
  input  logic [SH_AMT_W-1:0]  req0_shamt,
  input  logic [TAG_W-1:0]     req0_tag,

  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [SH_DATA_W-1:0] req1_data,
  input  logic                 req1_dir,
  input  logic [SH_AMT_W-1:0]  req1_shamt,
  input  logic [TAG_W-1:0]     req1_tag,

  output logic [SH_DATA_W-1:0] sh_data,
  output logic                 sh_dir,
  output logic [SH_AMT_W-1:0]  sh_shamt,
  input  logic [SH_DATA_W-1:0] sh_result,

  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [SH_DATA_W-1:0] rsp_data,
  output logic                 rsp_src,
  output logic [TAG_W-1:0]     rsp_tag
`ifdef SHIFT_ARB_PERF_EN
  ,
  output logic [31:0]          grant0_cnt,
  output logic [31:0]          grant1_cnt,
  output logic [31:0]          conflict_cnt
`endif
);

  logic       slot_free;
  logic [1:0] grant;
  logic       any_grant;
  logic       grant_id;
  sh_req_t    sh_req;
  logic [TAG_W-1:0] grant_tag;

  // The slot can take a new result if empty or if it drains this cycle.
  assign slot_free = !rsp_valid || rsp_ready;

  rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (slot_free),
    .valid   ({req1_valid, req0_valid}),
    .grant   (grant)
  );

  assign any_grant  = |grant;
  assign grant_id   = grant[1];
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Idle cycles drive zeros so the shifter inputs stay quiet.
  always_comb begin
    sh_req    = '0;
    grant_tag = '0;
    if (grant[0]) begin
      sh_req    = '{data: req0_data, dir: req0_dir, shamt: req0_shamt};
      grant_tag = req0_tag;
    end else if (grant[1]) begin
      sh_req    = '{data: req1_data, dir: req1_dir, shamt: req1_shamt};
      grant_tag = req1_tag;
    end
  end

  assign sh_data  = sh_req.data;
  assign sh_dir   = sh_req.dir;
  assign sh_shamt = sh_req.shamt;

  // A grant refills the slot even while it drains, so results go back to back.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_src   <= REQ_ALU;
      rsp_tag   <= '0;
    end else if (any_grant) begin
      rsp_valid <= 1'b1;
      rsp_data  <= sh_result;
      rsp_src   <= grant_id;
      rsp_tag   <= grant_tag;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef SHIFT_ARB_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant0_cnt   <= '0;
      grant1_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (grant[0]) grant0_cnt <= grant0_cnt + 32'd1;
      if (grant[1]) grant1_cnt <= grant1_cnt + 32'd1;
      if (req0_valid && req1_valid && slot_free)
        conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one external 32-bit barrel shifter (SRA/SLL, 5-bit shift amount) between two requesters:
  - req0: execute-stage ALU shift ops.
  - req1: secondary unit, e.g. branch-predictor index/hash logic.
- Round-robin arbitration, valid/ready handshake on each side.
- Result is registered in a single output slot, so latency is 1 cycle from accept to result.
- Sits between the requesters and the shared shifter instance; the shifter itself stays combinational and outside this block.

Parameters:
TAG_W, 4, width of the opaque tag carried from request to response

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a request
req0_ready  output  1  requester 0 request accepted this cycle
req0_data  input  32  operand to shift
req0_dir  input  1  0 = SRA, 1 = SLL
req0_shamt  input  5  shift amount
req0_tag  input  TAG_W  returned with the result
req1_valid, req1_ready, req1_data, req1_dir, req1_shamt, req1_tag  same as req0, for requester 1
sh_data  output  32  to shared shifter operand
sh_dir  output  1  to shared shifter direction select
sh_shamt  output  5  to shared shifter amount
sh_result  input  32  from shared shifter, combinational in sh_*
rsp_valid  output  1  result slot occupied
rsp_ready  input  1  consumer takes result
rsp_data  output  32  registered shift result
rsp_src  output  1  requester id of result
rsp_tag  output  TAG_W  tag of result

Behaviour:
- Clock and reset: one clock `clock`; reset `reset_n` is asynchronous, active-low.
- Reset values:
  - rsp_valid = 0; rsp_data = 0; rsp_src = 0; rsp_tag = 0.
  - last_grant = 1, so requester 0 wins the first tie.
- Slot free: `slot_free = !rsp_valid || rsp_ready`.
- Grant, combinational, only when slot_free:
  - Only one requester valid: it is granted.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant.
- Handshake:
  - `reqN_ready = grantN`.
  - reqN_ready may depend on reqN_valid and rsp_ready.
  - Requesters must hold payload stable while valid && !ready; no request is dropped.
- Shifter drive:
  - sh_data, sh_dir, sh_shamt = payload of the granted requester.
  - No grant: all drive 0 (shifter output ignored).
- On a grant, at the next clock edge:
  - rsp_valid <= 1.
  - rsp_data <= sh_result; rsp_src <= granted id; rsp_tag <= granted tag.
  - last_grant <= granted id.
- No grant and rsp_ready: rsp_valid <= 0; data fields hold their value.
- Slot full and !rsp_ready:
  - No grant; both req_ready = 0.
  - rsp_* hold their values.
- Simultaneous drain and grant: rsp_ready && rsp_valid in the same cycle as a new grant. The slot is refilled and stays valid, giving back-to-back throughput of 1 result per cycle.
- Fairness: with both requesters continuously valid and rsp_ready = 1, grants alternate 0,1,0,1...
- Width rules:
  - shamt is 0..31; shamt = 0 returns data unchanged.
  - SRA sign-fills from bit 31.
- Reset mid-operation: an in-flight result is discarded, rsp_valid is forced to 0 asynchronously, and last_grant returns to 1.

Optional Feature:
- Macro: SHIFT_ARB_PERF_EN.
- Defined: adds output ports grant0_cnt [31:0], grant1_cnt [31:0] and conflict_cnt [31:0].
  - grantN_cnt increments on each grant to requester N.
  - conflict_cnt increments on each cycle where both req_valid = 1 and slot_free.
  - All three reset to 0 and wrap at 2^32.
- Undefined: these ports and registers do not exist; arbitration behaviour is identical.

Decomposition:
- Shared package holds:
  - constants SH_DATA_W = 32, SH_AMT_W = 5;
  - SH_DIR_SRA = 0, SH_DIR_SLL = 1;
  - requester ids REQ_ALU = 0, REQ_AUX = 1.
- One natural sub-module: rr_arb2, a 2-way round-robin grant with last_grant state and an enable (slot_free).
- Payload mux and output register stay in the top level.

Test Plan:
- Reset then idle: rsp_valid = 0, both ready = 0 when neither valid, sh_* = 0.
- req0 only, data = 0x8000_0010, dir = SRA, shamt = 4, tag = 3 → next cycle rsp_valid = 1, rsp_data = 0xF800_0001, rsp_src = 0, rsp_tag = 3.
- Both valid continuously, rsp_ready = 1:
  - req0 SLL 0x1 by 31, req1 SRA 0x7FFF_FFFF by 31.
  - Grants alternate 0,1,0,1 beginning with 0.
  - Results alternate 0x8000_0000 / 0x0000_0000, one per cycle.
- Backpressure: rsp_ready = 0 with the slot full.
  - Both req_ready = 0 and rsp fields stable for 5 cycles.
  - Raise rsp_ready: same-cycle drain + refill, no bubble.
- Assert reset_n low while rsp_valid = 1 → rsp_valid = 0 immediately; after release, req1 gets no grant priority (tie goes to 0).
- SHIFT_ARB_PERF_EN defined: 10 contended cycles → conflict_cnt = 10, grant0_cnt = 5, grant1_cnt = 5.
